// File: rtl/riscv_inst_decode_queue.sv
// Streaming RV32/64 decoder: classifies, extracts fields, sign-extends
// immediates and queues results in a small FIFO with saturating stats.
module riscv_inst_decode_queue #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_inst,
  input  logic [XLEN-1:0]  in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2:0]       out_type,
  output logic [4:0]       out_rd,
  output logic [4:0]       out_rs1,
  output logic [4:0]       out_rs2,
  output logic [2:0]       out_funct3,
  output logic [6:0]       out_funct7,
  output logic [XLEN-1:0]  out_imm,
  output logic [XLEN-1:0]  out_pc,
  output logic             out_illegal,
  output logic [CNT_W-1:0] cnt_decoded,
  output logic [CNT_W-1:0] cnt_illegal
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [2:0] T_R   = 3'd0;
  localparam logic [2:0] T_I   = 3'd1;
  localparam logic [2:0] T_S   = 3'd2;
  localparam logic [2:0] T_B   = 3'd3;
  localparam logic [2:0] T_U   = 3'd4;
  localparam logic [2:0] T_J   = 3'd5;
  localparam logic [2:0] T_C0  = 3'd6;
  localparam logic [2:0] T_ILL = 3'd7;

  typedef struct packed {
    logic [2:0]      typ;
    logic [31:0]     inst;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc;
  } entry_t;

  entry_t        mem [DEPTH];
  entry_t        dec;
  entry_t        head;
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW:0]   count;
  logic          full;
  logic          push;
  logic          pop;
  logic          bad;
  logic [2:0]    typ;
  logic [6:0]    opc;
  logic [2:0]    f3;
  logic [6:0]    f7;

  assign opc = in_inst[6:0];
  assign f3  = in_inst[14:12];
  assign f7  = in_inst[31:25];

  always_comb begin
    typ = T_ILL;
    bad = 1'b0;
    unique case (opc)
      7'b0110011: begin
        typ = T_R;
        bad = !(f7 == 7'h00 || f7 == 7'h20)
           || (f7 == 7'h20 && !(f3 == 3'b000 || f3 == 3'b101));
      end
      7'b0010011: begin
        typ = T_I;
        bad = (f3 == 3'b001 && f7 != 7'h00)
           || (f3 == 3'b101 && f7 != 7'h00 && f7 != 7'h20);
      end
      7'b0100011: begin
        typ = T_S;
        bad = f3 > 3'b010;
      end
      7'b1100011: begin
        typ = T_B;
        bad = f3 == 3'b010 || f3 == 3'b011;
      end
      7'b0010111: typ = T_U;
      7'b1101111: typ = T_J;
      7'b0001011: begin
        typ = T_C0;
        bad = f3 != 3'b000;
      end
      default: bad = 1'b1;
    endcase
    if (bad) typ = T_ILL;
  end

  always_comb begin
    dec      = '0;
    dec.typ  = typ;
    dec.inst = in_inst;
    dec.pc   = in_pc;
    unique case (typ)
      T_I: dec.imm = XLEN'($signed(in_inst[31:20]));
      T_S: dec.imm = XLEN'($signed({in_inst[31:25], in_inst[11:7]}));
      T_B: dec.imm = XLEN'($signed({in_inst[31], in_inst[7],
                                    in_inst[30:25], in_inst[11:8],
                                    1'b0}));
      T_U: dec.imm = XLEN'($signed({in_inst[31:12], 12'h000}));
      T_J: dec.imm = XLEN'($signed({in_inst[31], in_inst[19:12],
                                    in_inst[20], in_inst[30:21],
                                    1'b0}));
      default: dec.imm = '0;
    endcase
  end

  assign full      = count == (AW+1)'(DEPTH);
  assign out_valid = count != '0;
  assign in_ready  = !flush && (!full || (out_valid && out_ready));
  assign push      = in_valid && in_ready;
  // flush wins over a simultaneous pop
  assign pop       = out_valid && out_ready && !flush;

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= dec;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr        <= '0;
      rptr        <= '0;
      count       <= '0;
      cnt_decoded <= '0;
      cnt_illegal <= '0;
    end else begin
      if (flush) begin
        wptr  <= '0;
        rptr  <= '0;
        count <= '0;
      end else begin
        if (push) wptr <= wptr + 1'b1;
        if (pop)  rptr <= rptr + 1'b1;
        if (push && !pop) count <= count + 1'b1;
        if (pop && !push) count <= count - 1'b1;
      end
      if (push && cnt_decoded != '1)
        cnt_decoded <= cnt_decoded + CNT_W'(1);
      if (push && typ == T_ILL && cnt_illegal != '1)
        cnt_illegal <= cnt_illegal + CNT_W'(1);
    end
  end

  // empty queue presents all-zero data so reset leaves outputs at 0
  assign head        = out_valid ? mem[rptr] : '0;
  assign out_type    = head.typ;
  assign out_rd      = head.inst[11:7];
  assign out_rs1     = head.inst[19:15];
  assign out_rs2     = head.inst[24:20];
  assign out_funct3  = head.inst[14:12];
  assign out_funct7  = head.inst[31:25];
  assign out_imm     = head.imm;
  assign out_pc      = head.pc;
  assign out_illegal = out_valid && head.typ == T_ILL;

endmodule

// File: tb/tb_riscv_inst_decode_queue.sv
// Scoreboard bench for riscv_inst_decode_queue: XLEN=32 and XLEN=64
// instances fed the same stream, CNT_W=4 for saturation.
module tb_riscv_inst_decode_queue;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_inst = '0;
  logic [31:0] in_pc = '0;
  logic        out_ready = 1'b0;

  logic        in_ready, out_valid, out_illegal;
  logic [2:0]  out_type, out_funct3;
  logic [4:0]  out_rd, out_rs1, out_rs2;
  logic [6:0]  out_funct7;
  logic [31:0] out_imm, out_pc;
  logic [3:0]  cnt_decoded, cnt_illegal;

  logic        in_ready64, out_valid64, out_illegal64;
  logic [2:0]  out_type64, out_funct3_64;
  logic [4:0]  out_rd64, out_rs1_64, out_rs2_64;
  logic [6:0]  out_funct7_64;
  logic [63:0] out_imm64, out_pc64;
  logic [15:0] cnt_decoded64, cnt_illegal64;

  always #5 clk = ~clk;

  riscv_inst_decode_queue #(.XLEN(32), .DEPTH(4), .CNT_W(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_inst(in_inst), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_type(out_type), .out_rd(out_rd),
    .out_rs1(out_rs1), .out_rs2(out_rs2),
    .out_funct3(out_funct3), .out_funct7(out_funct7),
    .out_imm(out_imm), .out_pc(out_pc),
    .out_illegal(out_illegal),
    .cnt_decoded(cnt_decoded), .cnt_illegal(cnt_illegal)
  );

  riscv_inst_decode_queue #(.XLEN(64), .DEPTH(4), .CNT_W(16)) u_dut64 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready64),
    .in_inst(in_inst), .in_pc({32'h0, in_pc}),
    .out_valid(out_valid64), .out_ready(out_ready),
    .out_type(out_type64), .out_rd(out_rd64),
    .out_rs1(out_rs1_64), .out_rs2(out_rs2_64),
    .out_funct3(out_funct3_64), .out_funct7(out_funct7_64),
    .out_imm(out_imm64), .out_pc(out_pc64),
    .out_illegal(out_illegal64),
    .cnt_decoded(cnt_decoded64), .cnt_illegal(cnt_illegal64)
  );

  typedef struct packed {
    logic [2:0]  typ;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [63:0] imm;
    logic [31:0] pc;
  } exp_t;

  exp_t       sb[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  logic [3:0] exp_dec = '0;
  logic [3:0] exp_ill = '0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp,
               $time);
    end
  endtask

  function automatic exp_t model(input logic [31:0] w,
                                 input logic [31:0] pc);
    exp_t       e;
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       ill;
    op = w[6:0];
    f3 = w[14:12];
    f7 = w[31:25];
    e = '0;
    e.rd = w[11:7];
    e.rs1 = w[19:15];
    e.rs2 = w[24:20];
    e.f3 = f3;
    e.f7 = f7;
    e.pc = pc;
    ill = 1'b0;
    if (op == 7'h33) begin
      e.typ = 3'd0;
      if (f7 == 7'h20) ill = !(f3 == 3'd0 || f3 == 3'd5);
      else ill = f7 != 7'h00;
    end else if (op == 7'h13) begin
      e.typ = 3'd1;
      e.imm = {{52{w[31]}}, w[31:20]};
      if (f3 == 3'd1) ill = f7 != 7'h00;
      if (f3 == 3'd5) ill = f7 != 7'h00 && f7 != 7'h20;
    end else if (op == 7'h23) begin
      e.typ = 3'd2;
      e.imm = {{52{w[31]}}, w[31:25], w[11:7]};
      ill = f3 > 3'd2;
    end else if (op == 7'h63) begin
      e.typ = 3'd3;
      e.imm = {{51{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
      ill = f3 == 3'd2 || f3 == 3'd3;
    end else if (op == 7'h17) begin
      e.typ = 3'd4;
      e.imm = {{32{w[31]}}, w[31:12], 12'h000};
    end else if (op == 7'h6F) begin
      e.typ = 3'd5;
      e.imm = {{43{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
    end else if (op == 7'h0B) begin
      e.typ = 3'd6;
      ill = f3 != 3'd0;
    end else begin
      ill = 1'b1;
    end
    if (ill) begin
      e.typ = 3'd7;
      e.imm = '0;
    end
    return e;
  endfunction

  // monitor: inputs change at posedge+1, so negedge shows next-edge events
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      chk("cnt_decoded", 64'(cnt_decoded), 64'(exp_dec));
      chk("cnt_illegal", 64'(cnt_illegal), 64'(exp_ill));
      chk("ready64", 64'(in_ready64), 64'(in_ready));
    end
    if (!rst_n || flush) begin
      sb.delete();
    end else begin
      if (out_valid && out_ready) begin
        chk("sb_nonempty", 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("type", 64'(out_type), 64'(e.typ));
          chk("rd", 64'(out_rd), 64'(e.rd));
          chk("rs1", 64'(out_rs1), 64'(e.rs1));
          chk("rs2", 64'(out_rs2), 64'(e.rs2));
          chk("funct3", 64'(out_funct3), 64'(e.f3));
          chk("funct7", 64'(out_funct7), 64'(e.f7));
          chk("imm", 64'(out_imm), 64'(e.imm[31:0]));
          chk("imm64", out_imm64, e.imm);
          chk("type64", 64'(out_type64), 64'(e.typ));
          chk("pc", 64'(out_pc), 64'(e.pc));
          chk("pc64", out_pc64, 64'(e.pc));
          chk("illegal", 64'(out_illegal), 64'(e.typ == 3'd7));
        end
      end
      if (in_valid && in_ready) sb.push_back(model(in_inst, in_pc));
    end
    if (!rst_n) begin
      exp_dec <= '0;
      exp_ill <= '0;
    end else if (in_valid && in_ready) begin
      if (exp_dec != 4'hF) exp_dec <= exp_dec + 4'd1;
      if (model(in_inst, in_pc).typ == 3'd7 && exp_ill != 4'hF)
        exp_ill <= exp_ill + 4'd1;
    end
  end

  // returns at posedge+1 just after the accepting edge
  task automatic send(input logic [31:0] w, input logic [31:0] pc);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_inst = w;
    in_pc = pc;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 50);
    if (!in_ready) chk("send_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  logic [6:0] ops [8];

  initial begin
    ops = '{7'h33, 7'h13, 7'h23, 7'h63, 7'h17, 7'h6F, 7'h0B, 7'h7F};
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_cnt", 64'(cnt_decoded), 64'd0);
    chk("rst_imm", 64'(out_imm), 64'd0);
    chk("rst_ready", 64'(in_ready), 64'd1);

    out_ready = 1'b1;
    send(32'hFFF00093, 32'h100);
    chk("addi_lat", 64'(out_valid), 64'd1);
    chk("addi_type", 64'(out_type), 64'd1);
    chk("addi_rd", 64'(out_rd), 64'd1);
    chk("addi_rs1", 64'(out_rs1), 64'd0);
    chk("addi_imm", 64'(out_imm), 64'hFFFFFFFF);
    chk("addi_imm64", out_imm64, 64'hFFFFFFFFFFFFFFFF);
    send(32'hFE000EE3, 32'h104);
    chk("beq_type", 64'(out_type), 64'd3);
    chk("beq_imm", 64'(out_imm), 64'hFFFFFFFC);
    send(32'h008000EF, 32'h108);
    chk("jal_type", 64'(out_type), 64'd5);
    chk("jal_rd", 64'(out_rd), 64'd1);
    chk("jal_imm", 64'(out_imm), 64'h8);
    send(32'h12345297, 32'h10C);
    chk("auipc_type", 64'(out_type), 64'd4);
    chk("auipc_rd", 64'(out_rd), 64'd5);
    chk("auipc_imm", 64'(out_imm), 64'h12345000);
    idle(2);

    do_reset();
    send(32'h0000707F, 32'h200);
    chk("unk_type", 64'(out_type), 64'd7);
    chk("unk_ill", 64'(out_illegal), 64'd1);
    chk("unk_imm", 64'(out_imm), 64'd0);
    send(32'h40001013, 32'h204);
    chk("slli_type", 64'(out_type), 64'd7);
    send(32'h40000033, 32'h208);
    chk("sub_type", 64'(out_type), 64'd0);
    chk("sub_ill", 64'(out_illegal), 64'd0);
    chk("trio_ill", 64'(cnt_illegal), 64'd2);
    chk("trio_dec", 64'(cnt_decoded), 64'd3);
    idle(2);

    out_ready = 1'b0;
    for (int i = 0; i < 4; i++)
      send(32'h00100093 + (i << 20), 32'h300 + 4 * i);
    chk("full_ready", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    send(32'h00500093, 32'h310);
    out_ready = 1'b0;
    #1;
    chk("swap_full", 64'(in_ready), 64'd0);
    chk("swap_valid", 64'(out_valid), 64'd1);
    out_ready = 1'b1;
    idle(6);
    chk("drain_valid", 64'(out_valid), 64'd0);

    out_ready = 1'b0;
    for (int i = 0; i < 3; i++)
      send(32'h00208133 + (i << 7), 32'h400 + 4 * i);
    in_valid = 1'b1;
    in_inst = 32'h00000013;
    flush = 1'b1;
    #1;
    chk("flush_ready", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush_valid", 64'(out_valid), 64'd0);
    chk("flush_dec", 64'(cnt_decoded), 64'd11);
    chk("flush_ill", 64'(cnt_illegal), 64'd2);

    send(32'h00000013, 32'h500);
    send(32'h00000013, 32'h504);
    do_reset();
    chk("rstq_valid", 64'(out_valid), 64'd0);
    chk("rstq_dec", 64'(cnt_decoded), 64'd0);
    chk("rstq_ill", 64'(cnt_illegal), 64'd0);
    chk("rstq_pc", 64'(out_pc), 64'd0);

    out_ready = 1'b1;
    for (int i = 0; i < 20; i++)
      send({$urandom_range(0, 32'h1FFFFFF) & 32'h1FFFFFF, 7'h7F}
           & 32'hFFFFFFFF, 32'h600 + 4 * i);
    chk("sat_dec", 64'(cnt_decoded), 64'd15);
    chk("sat_ill", 64'(cnt_illegal), 64'd15);
    send(32'h0000007F, 32'h700);
    chk("hold_dec", 64'(cnt_decoded), 64'd15);
    chk("hold_ill", 64'(cnt_illegal), 64'd15);
    idle(2);

    do_reset();
    for (int i = 0; i < 60; i++) begin
      logic [31:0] w;
      w = $urandom;
      w[6:0] = ops[$urandom_range(0, 7)];
      out_ready = ($urandom_range(0, 3) != 0) || (sb.size() >= 4);
      send(w, 32'h1000 + 4 * i);
    end
    out_ready = 1'b1;
    idle(8);
    chk("sb_drained", 64'(sb.size()), 64'd0);
    chk("end_valid", 64'(out_valid), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp,
             n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/riscv_inst_decode_queue.md
Name: riscv_inst_decode_queue

Overview:
- Parametrised streaming RISC-V instruction decoder with an output queue.
- Accepts 32-bit instruction words with their PC over a valid/ready handshake.
- Classifies each word by format (R/I/S/B/U/J/custom-0) and extracts fields.
- Assembles and sign-extends the immediate to XLEN bits, flags illegal encodings, and buffers results in a DEPTH-entry FIFO. The FIFO feeds the execute-side model and the scoreboard.
- Keeps saturating decode/illegal statistics counters.

Parameters:
- XLEN, 32, datapath width for immediate and PC (legal: 32 or 64).
- DEPTH, 4, output FIFO entries (power of two, >=2).
- CNT_W, 16, width of statistics counters.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst_n  input  1  synchronous active-low reset.
- flush  input  1  discard all queued entries.
- in_valid  input  1  instruction present.
- in_ready  output  1  decoder can accept.
- in_inst  input  32  raw instruction word.
- in_pc  input  XLEN  instruction address.
- out_valid  output  1  decoded entry at queue head.
- out_ready  input  1  consumer takes head.
- out_type  output  3  0=R 1=I 2=S 3=B 4=U 5=J 6=CUSTOM0 7=ILLEGAL.
- out_rd, out_rs1, out_rs2  output  5 each  register fields (raw bits [11:7],[19:15],[24:20]).
- out_funct3  output  3  inst[14:12].
- out_funct7  output  7  inst[31:25].
- out_imm  output  XLEN  assembled, sign-extended immediate.
- out_pc  output  XLEN  PC of the head entry.
- out_illegal  output  1  head entry is illegal.
- cnt_decoded  output  CNT_W  accepted instructions.
- cnt_illegal  output  CNT_W  accepted illegal instructions.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on rst_n.
- Reset (rst_n=0 at a clk edge) clears:
  - FIFO pointers and count to 0, so out_valid=0.
  - both counters to 0.
  - all out_* data fields to 0.
  - Reset mid-operation drops all queued entries.
- Handshake:
  - Accept when in_valid && in_ready.
  - Pop when out_valid && out_ready.
  - in_inst/in_pc are sampled only on accept.
  - out_* are stable while out_valid && !out_ready.
- in_ready = !flush && (count<DEPTH || (out_valid && out_ready)); simultaneous push and pop while full is allowed.
- Latency: decode is combinational at the input and the result is written to the FIFO on accept. out_valid rises the cycle after accept when the queue was empty. Order is strict FIFO.
- Count: +1 on push only, -1 on pop only, unchanged on both. Pointers wrap modulo DEPTH.
- flush clears the queue at the next edge and has priority over pop. Push is blocked because in_ready=0. Counters are unaffected.
- Immediate assembly (R, CUSTOM0 and ILLEGAL give 0):
  - I: sext(inst[31:20]).
  - S: sext({inst[31:25],inst[11:7]}).
  - B: sext({inst[31],inst[7],inst[30:25],inst[11:8],1'b0}).
  - U: sext({inst[31:12],12'h000}).
  - J: sext({inst[31],inst[19:12],inst[20],inst[30:21],1'b0}).
- Opcode-to-type mapping:
  - 0110011 → R
  - 0010011 → I
  - 0100011 → S
  - 1100011 → B
  - 0010111 → U
  - 1101111 → J
  - 0001011 → CUSTOM0
  - anything else → ILLEGAL
- An encoding is illegal (out_type=7, out_illegal=1, imm=0) when:
  - the opcode is unknown; or
  - S with funct3>010; or
  - B with funct3 in {010,011}; or
  - R with funct7 not 0x00/0x20, or funct7=0x20 with funct3 not in {000,101}; or
  - I funct3=001 with inst[31:25]!=0; or
  - I funct3=101 with inst[31:25] not 0x00/0x20; or
  - CUSTOM0 with funct3!=000.
- Illegal entries are still queued in order. Register, funct and pc fields are passed through raw.
- Counters:
  - cnt_decoded increments on every accept.
  - cnt_illegal increments on an accept of an illegal word.
  - Both saturate at all-ones (no wrap) and clear only on reset.

Test Plan:
- Single words, XLEN=32, out_ready=1:
  - 0xFFF00093 → type=1, rd=1, rs1=0, imm=0xFFFFFFFF, out_valid exactly 1 cycle after accept.
  - 0xFE000EE3 → type=3, imm=0xFFFFFFFC.
- Further single words:
  - 0x008000EF → type=5, rd=1, imm=0x00000008.
  - 0x12345297 → type=4, rd=5, imm=0x12345000.
  - With XLEN=64, 0xFFF00093 → imm=0xFFFFFFFFFFFFFFFF.
- Illegal words:
  - 0x0000707F → type=7, out_illegal=1, imm=0.
  - 0x40001013 (slli, funct7=0x20) → illegal.
  - 0x40000033 (sub) → type=0, legal.
  - After these three accepts, cnt_illegal=2 and cnt_decoded=3.
- Backpressure, DEPTH=4, out_ready=0, offer 5 words:
  - in_ready drops after the 4th accept.
  - Raise out_ready while full with in_valid=1 → push and pop in the same cycle, count stays 4, all 5 words emerge in order.
- Flush and reset:
  - Assert flush with 3 entries queued and in_valid=1 → in_ready=0 that cycle, out_valid=0 next cycle, counters unchanged.
  - Drive rst_n=0 for one edge with 2 entries queued → out_valid=0, cnt_decoded=0, cnt_illegal=0.
- Saturation, CNT_W=4: accept 20 illegal words → cnt_decoded=cnt_illegal=15 and both hold.
